// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative divider.
//
// Holds the divider FSM state encodings, the ready/start level names, the
// zero word and the 64-bit double-register bus type used for {HI, LO}.
// -----------------------------------------------------------------------------
package div_pkg;

  // Divider FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // {remainder -> HI, quotient -> LO}
  typedef logic [63:0] DoubleRegBus;

  // Number of shift-subtract steps for a 32-bit quotient.
  localparam logic [5:0] DivIters = 6'd32;

endpackage

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit iterative restoring divider for the EX stage.
//
// One quotient bit is produced per clock. A divide is accepted in FREE when
// start_i is high and annul_i is low; the result appears with ready_o high
// 33 clocks after the accepting edge (1 clock for a zero divisor) and is held
// in END until start_i drops.
//
// Handshake: start_i is a level request held high by the pipeline until it
// has consumed the result; ready_o is high only in END. While a request is
// outstanding and no result is available, stallreq_o freezes the pipeline.
// annul_i cancels an in-flight divide (BYZERO/ON) and is ignored in END.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   start_i       in   1   divide request, held until result consumed
//   annul_i       in   1   abort in-flight divide
//   signed_div_i  in   1   1 = div, 0 = divu (only with DIV_SIGNED_EN)
//   opdata1_i     in  32   dividend
//   opdata2_i     in  32   divisor
//   result_o      out 64   {remainder -> HI, quotient -> LO}
//   ready_o       out  1   result valid
//   stallreq_o    out  1   EX stall request (combinational)
//
// Build option: define DIV_SIGNED_EN to support signed division. Without it
// every operand is treated as unsigned and signed_div_i is ignored.
// -----------------------------------------------------------------------------
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  r_state;
  div_state_e  w_next_state;

  logic [5:0]  r_cnt;
  // r_work[64:32] : partial remainder, r_work[31:0] : dividend bits shifting
  // out of the top while quotient bits shift in at the bottom.
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  DoubleRegBus r_result;
  logic        r_ready;

  logic        w_take;
  logic        w_cnt_done;
  logic [31:0] w_op1_abs;
  logic [31:0] w_op2_abs;
  logic [32:0] w_shifted;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  DoubleRegBus w_final;
  logic        w_unused_top;

  assign w_take     = (start_i == DivStart) && !annul_i;
  assign w_cnt_done = (r_cnt == DivIters);

  // ---------------------------------------------------------------------------
  // Operand conditioning and sign correction
  // ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_op1_abs = (signed_div_i && opdata1_i[31]) ? (ZeroWord - opdata1_i) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[31]) ? (ZeroWord - opdata2_i) : opdata2_i;

  // Signs are captured at the start edge so later operand changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == DivFree && w_take) begin
      r_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
      r_neg_r <= signed_div_i & opdata1_i[31];
    end
  end

  // Quotient negated when signs differ; remainder follows the dividend sign.
  // 0x80000000 / -1 wraps naturally: |q| = 0x80000000, negated is itself.
  assign w_final = {(r_neg_r ? (ZeroWord - w_rem)  : w_rem),
                    (r_neg_q ? (ZeroWord - w_quot) : w_quot)};
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div_i;
  assign w_op1_abs       = opdata1_i;
  assign w_op2_abs       = opdata2_i;
  assign w_final         = {w_rem, w_quot};
`endif

  // ---------------------------------------------------------------------------
  // Restoring shift-subtract step
  // ---------------------------------------------------------------------------
  // The partial remainder is always below the divisor, so it fits in 32 bits;
  // shifting in the next dividend bit needs 33 bits, and the compare is done
  // one bit wider so the borrow is the "remainder < divisor" flag.
  assign w_shifted    = {r_work[63:32], r_work[31]};
  assign w_diff       = {1'b0, w_shifted} - {2'b00, r_divisor};
  assign w_ge         = ~w_diff[33];
  assign w_quot       = r_work[31:0];
  assign w_rem        = r_work[63:32];
  assign w_unused_top = r_work[64];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DivFree: begin
        if (w_take) begin
          w_next_state = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        w_next_state = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          w_next_state = DivFree;
        end else if (w_cnt_done) begin
          w_next_state = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_next_state = DivFree;
        end
      end
      default: w_next_state = DivFree;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 6'd0;
      r_work    <= 65'd0;
      r_divisor <= ZeroWord;
      r_result  <= {ZeroWord, ZeroWord};
      r_ready   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (w_take) begin
            r_cnt     <= 6'd0;
            r_work    <= {33'd0, w_op1_abs};
            r_divisor <= w_op2_abs;
          end
        end
        DivByZero: begin
          r_result <= {ZeroWord, ZeroWord};
          r_ready  <= annul_i ? DivResultNotReady : DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            r_result <= {ZeroWord, ZeroWord};
            r_ready  <= DivResultNotReady;
          end else if (!w_cnt_done) begin
            r_work <= w_ge ? {w_diff[32:0], r_work[30:0], 1'b1}
                           : {w_shifted,    r_work[30:0], 1'b0};
            r_cnt  <= r_cnt + 6'd1;
          end else begin
            r_result <= w_final;
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_result <= {ZeroWord, ZeroWord};
            r_ready  <= DivResultNotReady;
          end
        end
        default: begin
          r_ready <= DivResultNotReady;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule
